a_mat_mult: RTL and testbench

Matrix-vector engine consuming the 8x4 coefficient ROM. Loads a 4-element input vector x over a valid/ready stream, sequences the 16 ROM addresses, and multiply-accumulates two coefficients per cycle into eight accumulators. It then streams y = A·x (8 results) downstream over valid/ready. It sits directly downstream of the coefficient ROM and drives that ROM's address port.

---
 rtl/amm_pkg.sv | 20 ++
 rtl/amm_mac_lane.sv | 42 ++++
 rtl/a_mat_mult.sv | 135 +++++++++++++
 tb/tb_a_mat_mult.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amm_pkg.sv
// Shared widths, FSM states and ROM address packing for the a_mat_mult engine.
package amm_pkg;

    localparam int unsigned AMM_DATA_W = 8;
    localparam int unsigned AMM_COEF_W = 7;
    localparam int unsigned AMM_ACC_W  = AMM_DATA_W + AMM_COEF_W + 2;

    typedef enum logic [1:0] {
        LOAD,
        FETCH,
        DRAIN,
        OUT
    } amm_state_t;

    // ROM address is column-major: {col, pair}.
    function automatic logic [3:0] rom_addr_pack(input logic [1:0] col, input logic [1:0] pair);
        return {col, pair};
    endfunction

endpackage

// File: rtl/amm_mac_lane.sv
// One multiply-accumulate lane: four accumulators indexed by ROM pair, with
// synchronous clear and a separate read port for the output stream.
module amm_mac_lane
    import amm_pkg::*;
#(
    parameter int unsigned DATA_W = AMM_DATA_W,
    parameter int unsigned COEF_W = AMM_COEF_W,
    parameter int unsigned ACC_W  = AMM_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [1:0]        sel,
    input  logic [COEF_W-1:0] coef,
    input  logic [DATA_W-1:0] x,
    input  logic [1:0]        rd_sel,
    output logic [ACC_W-1:0]  rd_data
);

    logic [ACC_W-1:0]         acc [4];
    logic [DATA_W+COEF_W-1:0] prod;

    always_comb begin
        prod = {{DATA_W{1'b0}}, coef} * {{COEF_W{1'b0}}, x};
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
        end else if (en) begin
            acc[sel] <= acc[sel] + {{(ACC_W-DATA_W-COEF_W){1'b0}}, prod};
        end
    end

    always_comb begin
        rd_data = acc[rd_sel];
    end

endmodule

// File: rtl/a_mat_mult.sv
// Matrix-vector engine: y = A*x over the 8x4 coefficient ROM, streamed out over valid/ready.
// Define A_MAT_MULT_SAT_EN to clamp out_data to 16 bits (accumulation is unaffected).
module a_mat_mult
    import amm_pkg::*;
#(
    parameter int unsigned DATA_W = AMM_DATA_W,
    parameter int unsigned COEF_W = AMM_COEF_W,
    parameter int unsigned ACC_W  = AMM_ACC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [3:0]          rom_addr,
    input  logic [2*COEF_W-1:0] A_input,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic [2:0]          out_idx,
    output logic                busy
);

    amm_state_t       state, state_n;
    logic [1:0]       ld_cnt;
    logic [DATA_W-1:0] x [4];
    logic [3:0]       k;
    logic [3:0]       mac_k;
    logic             mac_v;
    logic             load_done;
    logic [ACC_W-1:0] acc_even, acc_odd, acc_sel;

    assign load_done = (state == LOAD) && in_valid && (ld_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rom_addr  = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (load_done) state_n = FETCH;
            end
            FETCH: begin
                rom_addr = rom_addr_pack(k[3:2], k[1:0]);
                if (k == 4'd15) state_n = DRAIN;
            end
            DRAIN: state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready && (out_idx == 3'd7)) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // mac_v/mac_k lag k by one cycle to line up with the ROM's read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_cnt  <= '0;
            k       <= '0;
            mac_k   <= '0;
            mac_v   <= 1'b0;
            out_idx <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                x[i] <= '0;
            end
        end else begin
            mac_v <= (state == FETCH);
            mac_k <= k;
            case (state)
                LOAD: begin
                    k <= '0;
                    if (in_valid) begin
                        x[ld_cnt] <= in_data;
                        ld_cnt    <= ld_cnt + 2'd1;
                    end
                end
                FETCH: k <= k + 4'd1;
                DRAIN: out_idx <= '0;
                OUT:   if (out_ready) out_idx <= out_idx + 3'd1;
                default: ;
            endcase
        end
    end

    amm_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane_even (
        .clk     (clk),
        .rst     (rst),
        .clr     (load_done),
        .en      (mac_v),
        .sel     (mac_k[1:0]),
        .coef    (A_input[2*COEF_W-1:COEF_W]),
        .x       (x[mac_k[3:2]]),
        .rd_sel  (out_idx[2:1]),
        .rd_data (acc_even)
    );

    amm_mac_lane #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane_odd (
        .clk     (clk),
        .rst     (rst),
        .clr     (load_done),
        .en      (mac_v),
        .sel     (mac_k[1:0]),
        .coef    (A_input[COEF_W-1:0]),
        .x       (x[mac_k[3:2]]),
        .rd_sel  (out_idx[2:1]),
        .rd_data (acc_odd)
    );

    assign acc_sel = out_idx[0] ? acc_odd : acc_even;

    always_comb begin
        out_data = '0;
        if (out_valid) begin
`ifdef A_MAT_MULT_SAT_EN
            out_data = (|acc_sel[ACC_W-1:16]) ? {{(ACC_W-16){1'b0}}, 16'hFFFF} : acc_sel;
`else
            out_data = acc_sel;
`endif
        end
    end

endmodule

// File: tb/tb_a_mat_mult.sv
// Self-checking bench for a_mat_mult: ROM model, queue-based result model, directed and random runs.
module tb_a_mat_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [3:0]  rom_addr;
    logic [13:0] A_input = '0;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic [2:0]  out_idx;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          rom_all127 = 1'b0;
    int unsigned exp_val[$];
    int unsigned exp_idx[$];

`ifdef A_MAT_MULT_SAT_EN
    localparam bit          SAT     = 1'b1;
    localparam int unsigned LIT_MAX = 65535;
`else
    localparam bit          SAT     = 1'b0;
    localparam int unsigned LIT_MAX = 129540;
`endif

    int unsigned tab [8][4] = '{
        '{  3,  17, 100, 127},
        '{  5,   0,  64,   9},
        '{126,   1,   2,  33},
        '{  7,  88,  45,  12},
        '{ 50,  60,  70,  80},
        '{  0, 127,   1,  99},
        '{ 11,  22,  33,  44},
        '{127, 126, 125, 124}
    };

    a_mat_mult #(.DATA_W(8), .COEF_W(7), .ACC_W(17)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_addr  (rom_addr),
        .A_input   (A_input),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Coefficient ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (rom_all127)
            A_input <= {7'd127, 7'd127};
        else
            A_input <= {7'(tab[{rom_addr[1:0], 1'b0}][rom_addr[3:2]]),
                        7'(tab[{rom_addr[1:0], 1'b1}][rom_addr[3:2]])};
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned model_y(input int unsigned r, input int unsigned xv[4], input bit all127);
        int unsigned s = 0;
        for (int unsigned c = 0; c < 4; c++)
            s += (all127 ? 127 : tab[r][c]) * xv[c];
        if (SAT && s > 65535) s = 65535;
        return s;
    endfunction

    task automatic push_exp(input int unsigned xv[4]);
        for (int unsigned r = 0; r < 8; r++) begin
            exp_val.push_back(model_y(r, xv, rom_all127));
            exp_idx.push_back(r);
        end
    endtask

    // Result checker: every presented result must match the head of the model queue.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (exp_val.size() == 0) begin
                chk("unexpected_result", exp_val.size(), 1);
            end else begin
                chk("out_data", 32'(out_data), exp_val[0]);
                chk("out_idx", 32'(out_idx), exp_idx[0]);
                if (out_ready) begin
                    void'(exp_val.pop_front());
                    void'(exp_idx.pop_front());
                end
            end
        end
    end

    // Offers four elements; returns in cycle T+1 (just after the 4th handshake edge).
    task automatic send_vec(input int unsigned xv[4], input bit gaps);
        bit          hs;
        int unsigned n;
        for (int unsigned i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = 8'(xv[i]);
            hs = 1'b0;
            n  = 0;
            while (!hs && n < 50) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk); #1;
                n++;
            end
            if (!hs) chk("in_handshake_timeout", n, 0);
        end
        in_valid = 1'b0;
        push_exp(xv);
    endtask

    task automatic drain_results(input bit rnd);
        int unsigned n = 0;
        while (exp_val.size() != 0 && n < 400) begin
            chk("in_ready_while_busy", 32'(in_ready), 0);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) chk("drain_timeout", exp_val.size(), 0);
        out_ready = 1'b1;
        chk("in_ready_after_drain", 32'(in_ready), 1);
    endtask

    task automatic run_and_check(input int unsigned xv[4], input int unsigned lit[8]);
        out_ready = 1'b1;
        send_vec(xv, 1'b0);
        for (int unsigned k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rom_addr_seq", 32'(rom_addr), k);
            chk("busy_fetch", 32'(busy), 1);
            chk("in_ready_fetch", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_rom_addr", 32'(rom_addr), 0);
        chk("drain_busy", 32'(busy), 1);
        @(posedge clk); #1;
        for (int unsigned r = 0; r < 8; r++) begin
            @(negedge clk);
            chk("out_valid_stream", 32'(out_valid), 1);
            chk("out_idx_stream", 32'(out_idx), r);
            chk("out_data_literal", 32'(out_data), lit[r]);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("in_ready_t26", 32'(in_ready), 1);
        chk("out_valid_t26", 32'(out_valid), 0);
        chk("busy_t26", 32'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned xv[4];
        int unsigned lit[8];
        int unsigned n;
        int unsigned xi;
        bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // x = {1,0,0,0}: y[r] = A[r][0]
        xv  = '{1, 0, 0, 0};
        lit = '{3, 5, 126, 7, 50, 0, 11, 127};
        run_and_check(xv, lit);

        // All-127 ROM with all-255 x
        rom_all127 = 1'b1;
        xv  = '{255, 255, 255, 255};
        lit = '{LIT_MAX, LIT_MAX, LIT_MAX, LIT_MAX, LIT_MAX, LIT_MAX, LIT_MAX, LIT_MAX};
        run_and_check(xv, lit);
        rom_all127 = 1'b0;

        // Zero vector
        xv  = '{0, 0, 0, 0};
        lit = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_and_check(xv, lit);

        // Backpressure at out_idx = 3
        xv = '{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
        out_ready = 1'b1;
        send_vec(xv, 1'b0);
        n = 0;
        while (!(out_valid && out_idx == 3'd3) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_reach_idx3", 32'(n < 60), 1);
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_idx", 32'(out_idx), 3);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
        end
        drain_results(1'b0);

        // Reset mid-FETCH at rom_addr = 9
        xv = '{7, 8, 9, 10};
        send_vec(xv, 1'b0);
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("abort_rom_addr", 32'(rom_addr), 9);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_val.delete();
        exp_idx.delete();
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rom_addr0", 32'(rom_addr), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        xv  = '{2, 0, 0, 0};
        lit = '{6, 10, 252, 14, 100, 0, 22, 254};
        run_and_check(xv, lit);

        // Stalled input: in_valid = 1,0,0,1,1,0,1
        xv = '{11, 22, 33, 44};
        xi = 0;
        for (int unsigned j = 0; j < 7; j++) begin
            in_valid = pat[j];
            in_data  = pat[j] ? 8'(xv[xi]) : 8'hEE;
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 1);
            @(posedge clk); #1;
            if (pat[j]) xi++;
        end
        in_valid = 1'b0;
        push_exp(xv);
        chk("stall_fetch_busy", 32'(busy), 1);
        chk("stall_fetch_addr0", 32'(rom_addr), 0);
        @(posedge clk); #1;
        chk("stall_fetch_addr1", 32'(rom_addr), 1);
        drain_results(1'b0);

        // Random vectors, input gaps and output backpressure
        for (int unsigned v = 0; v < 16; v++) begin
            rom_all127 = (v % 5 == 4);
            xv = '{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255)};
            send_vec(xv, 1'b1);
            drain_results(1'b1);
        end
        rom_all127 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("results_outstanding", exp_val.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
